// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the SRAM slave responder.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave with a word-addressed SRAM; independent read and write FSMs,
// one outstanding burst each, all bursts treated as INCR of 4-byte beats.
module axi_sram_slave #(
    parameter int unsigned DEPTH = 1024
) (
    input logic             clk,
    input logic             reset,
    axi_sram_slave_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic       {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [31:0] r_mem [DEPTH];

    rstate_t     r_rstate;
    logic [3:0]  r_rcnt;
    logic [3:0]  r_rlen;
    logic [31:0] r_raddr;
    logic [3:0]  r_rid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;
    logic        r_arready;
    logic        r_rvalid;

    wstate_t     r_wstate;
    logic [3:0]  r_wcnt;
    logic [3:0]  r_wlen;
    logic [31:0] r_waddr;
    logic [3:0]  r_wid;
    logic        r_werr;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;

    logic [31:0] w_rnext;
    logic        w_rhit;
    logic [31:0] w_rword;
    logic        w_whit;
    logic        w_wend;
    logic        w_wfire;
    logic        w_unused;

    // Address of the beat the read data register loads next.
    assign w_rnext = (r_rstate == R_IDLE) ? bus.araddr : r_raddr + 32'd4;
    assign w_rhit  = ({2'b00, w_rnext[31:2]} < 32'(DEPTH));
    assign w_rword = w_rhit ? r_mem[w_rnext[AW+1:2]] : '0;

    assign w_whit  = ({2'b00, r_waddr[31:2]} < 32'(DEPTH));
    assign w_wend  = (r_wcnt == r_wlen);
    assign w_wfire = bus.wvalid & r_wready & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            r_rlen    <= '0;
            r_raddr   <= '0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        r_rid     <= bus.arid;
                        r_rlen    <= bus.arlen[3:0];
                        r_raddr   <= bus.araddr;
                        r_rcnt    <= '0;
                        r_rdata   <= w_rword;
                        r_rresp   <= w_rhit ? 2'b00 : 2'b10;
                        r_rlast   <= (bus.arlen[3:0] == 4'd0);
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        if (r_rlast) begin
                            r_rlast   <= 1'b0;
                            r_rvalid  <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt + 4'd1;
                            r_raddr <= w_rnext;
                            r_rdata <= w_rword;
                            r_rresp <= w_rhit ? 2'b00 : 2'b10;
                            r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_wcnt    <= '0;
            r_wlen    <= '0;
            r_waddr   <= '0;
            r_wid     <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (bus.awvalid) begin
                        r_wid     <= bus.awid;
                        r_wlen    <= bus.awlen[3:0];
                        r_waddr   <= bus.awaddr;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.wvalid) begin
                        // Beat count, not wlast, ends the burst; a wlast mismatch only flags an error.
                        if (!w_whit || (bus.wlast != w_wend))
                            r_werr <= 1'b1;
                        if (w_wend) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wcnt  <= r_wcnt + 4'd1;
                            r_waddr <= r_waddr + 32'd4;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Separate process with nonblocking writes keeps same-cycle reads read-first.
    always_ff @(posedge clk) begin
        if (w_wfire && w_whit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.wstrb[i])
                    r_mem[r_waddr[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.arready = r_arready & ~reset;
    assign bus.rvalid  = r_rvalid  & ~reset;
    assign bus.rlast   = r_rlast   & ~reset;
    assign bus.rid     = reset ? '0 : r_rid;
    assign bus.rdata   = reset ? '0 : r_rdata;
    assign bus.rresp   = reset ? '0 : r_rresp;

    assign bus.awready = r_awready & ~reset;
    assign bus.wready  = r_wready  & ~reset;
    assign bus.bvalid  = r_bvalid  & ~reset;
    assign bus.bid     = reset ? '0 : r_wid;
    assign bus.bresp   = (reset || !r_werr) ? 2'b00 : 2'b10;

    assign w_unused = ^{bus.arlen[7:4], bus.arsize, bus.arburst, bus.arlock, bus.arcache,
                        bus.arprot, bus.awlen[7:4], bus.awsize, bus.awburst, bus.awlock,
                        bus.awcache, bus.awprot, bus.wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, errors, backpressure, overlap, reset.
module tb_axi_sram_slave;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    axi_sram_slave_if bus ();

    axi_sram_slave #(.DEPTH(1024)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp_line(input logic [31:0] base);
        for (int n = 0; n < 16; n++) begin
            exp_data[n] = base + 32'(n);
            exp_resp[n] = 2'b00;
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] d0, input logic [3:0] strb, input int wlast_beat,
                            output logic [1:0] resp, output logic [3:0] got_bid);
        int guard;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = {4'h0, len};
        bus.awvalid = 1'b1;
        guard = 0;
        while (!bus.awready && guard < 100) begin step(); guard++; end
        if (guard >= 100) check_eq("aw_timeout", 1, 0);
        step();
        bus.awvalid = 1'b0;
        check_eq("wready_after_aw", bus.wready, 1);
        for (int n = 0; n <= int'(len); n++) begin
            bus.wdata  = d0 + 32'(n);
            bus.wstrb  = strb;
            bus.wlast  = (n == wlast_beat);
            bus.wvalid = 1'b1;
            guard = 0;
            while (!bus.wready && guard < 100) begin step(); guard++; end
            if (guard >= 100) check_eq("w_timeout", 1, 0);
            step();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check_eq("bvalid_after_wlast", bus.bvalid, 1);
        resp    = bus.bresp;
        got_bid = bus.bid;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check_eq("awready_after_b", bus.awready, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input bit stall);
        int guard;
        int beats;
        int cyc;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = {4'h0, len};
        bus.arvalid = 1'b1;
        guard = 0;
        while (!bus.arready && guard < 100) begin step(); guard++; end
        if (guard >= 100) check_eq("ar_timeout", 1, 0);
        step();
        bus.arvalid = 1'b0;
        check_eq("rvalid_after_ar", bus.rvalid, 1);
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < 200) begin
            bus.rready = stall ? ((cyc % 3) == 0) : 1'b1;
            check_eq("rvalid_held", bus.rvalid, 1);
            if (bus.rvalid) begin
                check_eq("rdata", bus.rdata, exp_data[beats]);
                check_eq("rresp", bus.rresp, exp_resp[beats]);
                check_eq("rid", bus.rid, id);
                check_eq("rlast", bus.rlast, beats == int'(len));
                if (bus.rready) beats++;
            end
            step();
            cyc++;
        end
        bus.rready = 1'b0;
        check_eq("r_beats", beats, int'(len) + 1);
        check_eq("arready_after_rlast", bus.arready, 1);
        check_eq("rvalid_after_rlast", bus.rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp;
        logic [3:0] bid_got;
        logic [1:0] resp2;
        logic [3:0] bid2;

        n_checks = 0;
        n_fail   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        repeat (3) step();
        check_eq("rst_arready", bus.arready, 0);
        check_eq("rst_awready", bus.awready, 0);
        check_eq("rst_wready", bus.wready, 0);
        check_eq("rst_rvalid", bus.rvalid, 0);
        check_eq("rst_bvalid", bus.bvalid, 0);
        check_eq("rst_rlast", bus.rlast, 0);
        check_eq("rst_rid", bus.rid, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_bid", bus.bid, 0);
        check_eq("rst_bresp", bus.bresp, 0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_arready", bus.arready, 1);
        check_eq("post_rst_awready", bus.awready, 1);
        check_eq("post_rst_wready", bus.wready, 0);

        // Single word write then read back.
        do_write(4'd3, 32'h10, 4'd0, 32'h1234_5678, 4'hF, 0, resp, bid_got);
        check_eq("single_bresp", resp, 2'b00);
        check_eq("single_bid", bid_got, 4'd3);
        exp_data[0] = 32'h1234_5678; exp_resp[0] = 2'b00;
        do_read(4'd1, 32'h10, 4'd0, 1'b0);

        // Cache line write then read.
        do_write(4'd5, 32'h40, 4'd3, 32'hA0, 4'hF, 3, resp, bid_got);
        check_eq("line_bresp", resp, 2'b00);
        check_eq("line_bid", bid_got, 4'd5);
        set_exp_line(32'hA0);
        do_read(4'd2, 32'h40, 4'd3, 1'b0);

        // Partial strobe merge.
        do_write(4'd0, 32'h0, 4'd0, 32'hFFFF_FFFF, 4'hF, 0, resp, bid_got);
        do_write(4'd0, 32'h0, 4'd0, 32'h1122_3344, 4'b0101, 0, resp, bid_got);
        check_eq("strobe_bresp", resp, 2'b00);
        exp_data[0] = 32'hFF22_FF44; exp_resp[0] = 2'b00;
        do_read(4'd7, 32'h0, 4'd0, 1'b0);

        // Backpressure on a 4-beat read.
        set_exp_line(32'hA0);
        do_read(4'd9, 32'h40, 4'd3, 1'b1);

        // Out of range read, and a burst crossing the top word.
        exp_data[0] = 32'h0; exp_resp[0] = 2'b10;
        do_read(4'd4, 32'h1000, 4'd0, 1'b0);
        do_write(4'd6, 32'hFFC, 4'd0, 32'h5A5A_0001, 4'hF, 0, resp, bid_got);
        check_eq("top_word_bresp", resp, 2'b00);
        exp_data[0] = 32'h5A5A_0001; exp_resp[0] = 2'b00;
        exp_data[1] = 32'h0;         exp_resp[1] = 2'b10;
        do_read(4'd4, 32'hFFC, 4'd1, 1'b0);
        do_write(4'd8, 32'h1000, 4'd0, 32'hDEAD_BEEF, 4'hF, 0, resp, bid_got);
        check_eq("oob_write_bresp", resp, 2'b10);
        check_eq("oob_write_bid", bid_got, 4'd8);

        // Early wlast: all beats taken, error reported, data still written.
        do_write(4'd2, 32'h80, 4'd3, 32'hB0, 4'hF, 1, resp, bid_got);
        check_eq("early_wlast_bresp", resp, 2'b10);
        set_exp_line(32'hB0);
        do_read(4'd3, 32'h80, 4'd3, 1'b0);
        do_write(4'd2, 32'h84, 4'd0, 32'hB1, 4'hF, 0, resp, bid_got);
        check_eq("err_cleared_bresp", resp, 2'b00);

        // Overlapped read and write on different lines.
        set_exp_line(32'hA0);
        fork
            do_write(4'hC, 32'hC0, 4'd3, 32'hC0, 4'hF, 3, resp2, bid2);
            do_read(4'hD, 32'h40, 4'd3, 1'b0);
        join
        check_eq("overlap_bresp", resp2, 2'b00);
        check_eq("overlap_bid", bid2, 4'hC);
        set_exp_line(32'hC0);
        do_read(4'hE, 32'hC0, 4'd3, 1'b0);

        // Reset during read beat 2.
        bus.arid = 4'd1; bus.araddr = 32'h40; bus.arlen = 8'd3; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        step();
        step();
        check_eq("pre_reset_beat2", bus.rdata, 32'hA2);
        reset = 1'b1;
        bus.rready = 1'b0;
        step();
        check_eq("mid_reset_rvalid", bus.rvalid, 0);
        check_eq("mid_reset_arready", bus.arready, 0);
        reset = 1'b0;
        #1;
        check_eq("release_arready", bus.arready, 1);
        check_eq("release_rvalid", bus.rvalid, 0);
        exp_data[0] = 32'h1234_5678; exp_resp[0] = 2'b00;
        do_read(4'd6, 32'h10, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
